// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the register file with clear sweep.
package reg_file_pkg;
  typedef enum logic {IDLE, SWEEP} state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
endpackage

// File: rtl/negate_n.sv
// Two's-complement negation, combinational; the carry out of the increment is dropped.
module negate_n #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = ~a + WIDTH'(1);
endmodule

// File: rtl/reg_file_n.sv
// 2R1W register file with optional negate-on-write and a DEPTH-cycle clear sweep.
// Reads are combinational with no bypass; writes and clr_req are dropped while busy.
module reg_file_n
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              wneg,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  regs [DEPTH];
  logic [WIDTH-1:0]  wdata_neg;
  logic [WIDTH-1:0]  wval;
  logic              wr_ok;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              done_nxt;

  negate_n #(.WIDTH(WIDTH)) u_neg (
    .a (wdata),
    .y (wdata_neg)
  );

  assign wval  = wneg ? wdata_neg : wdata;
  assign busy  = (state == SWEEP);
  // Register 0 is hard-wired when ZERO_REG is set, so its writes never land.
  assign wr_ok = we && !busy && !((ZERO_REG != 0) && (waddr == '0));

  assign rdata_a = ((ZERO_REG != 0) && (raddr_a == '0)) ? '0 : regs[raddr_a];
  assign rdata_b = ((ZERO_REG != 0) && (raddr_b == '0)) ? '0 : regs[raddr_b];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      if (busy) begin
        regs[cnt] <= '0;
      end else if (wr_ok) begin
        regs[waddr] <= wval;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_n.sv
// Directed bench for reg_file_n: a ZERO_REG=1 and a ZERO_REG=0 instance sharing stimulus.
module tb_reg_file_n;
  logic        clk = 1'b0;
  logic        rst;
  logic        we, wneg, clr_req;
  logic [2:0]  waddr, raddr_a, raddr_b;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b, rdata_a2, rdata_b2;
  logic        busy, done, busy2, done2;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  reg_file_n #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .wneg(wneg), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .clr_req(clr_req), .busy(busy), .done(done)
  );

  reg_file_n #(.WIDTH(32), .DEPTH(8), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .we(we), .wneg(wneg), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a2), .rdata_b(rdata_b2),
    .clr_req(clr_req), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic n);
    we = 1'b1; wneg = n; waddr = a; wdata = d;
    step();
    we = 1'b0; wneg = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 1; i < 8; i++) wr(3'(i), base + 32'(i), 1'b0);
  endtask

  task automatic all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), rdata_a, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wneg = 1'b0; clr_req = 1'b0;
    waddr = 3'd0; wdata = 32'h0; raddr_a = 3'd0; raddr_b = 3'd1;
    #2;
    chk("rst_rdata_a", rdata_a, 32'h0);
    chk("rst_rdata_b", rdata_b, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_nz_rdata_b", rdata_b2, 32'h0);
    chk("rst_nz_busy_done", {30'h0, busy2, done2}, 32'h0);
    step();
    rst = 1'b0;

    // First write after reset, with a same-cycle read of the target address.
    we = 1'b1; waddr = 3'd3; wdata = 32'hDEADBEEF; raddr_a = 3'd3;
    #1;
    chk("same_cycle_old", rdata_a, 32'h0);
    step();
    we = 1'b0;
    chk("write_visible", rdata_a, 32'hDEADBEEF);

    wr(3'd2, 32'd5, 1'b1);
    raddr_b = 3'd2; #1;
    chk("neg_5", rdata_b, 32'hFFFFFFFB);
    wr(3'd4, 32'h80000000, 1'b1);
    raddr_b = 3'd4; #1;
    chk("neg_min", rdata_b, 32'h80000000);
    wr(3'd5, 32'h77, 1'b0);
    wr(3'd5, 32'h0, 1'b1);
    raddr_b = 3'd5; #1;
    chk("neg_zero", rdata_b, 32'h0);

    wr(3'd0, 32'h1234, 1'b0);
    raddr_a = 3'd0; #1;
    chk("zero_reg_on", rdata_a, 32'h0);
    chk("zero_reg_off", rdata_a2, 32'h1234);

    // Sweep: write and clr_req during busy must be dropped; reads see partial clear.
    fill(32'h100);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      chk($sformatf("sw1_busy_c%0d", i), {31'h0, busy}, {31'h0, (i <= 8)});
      chk($sformatf("sw1_done_c%0d", i), {31'h0, done}, {31'h0, (i == 9)});
      if (i == 3) begin
        raddr_a = 3'd5; raddr_b = 3'd1; #1;
        chk("sw1_uncleared", rdata_a, 32'h105);
        chk("sw1_cleared", rdata_b, 32'h0);
        we = 1'b1; waddr = 3'd1; wdata = 32'hFFFF;
      end
      clr_req = (i == 5);
      step();
      we = 1'b0; clr_req = 1'b0;
    end
    all_zero("sw1");

    // Back-to-back: clr_req in the done cycle restarts the sweep.
    fill(32'h300);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      chk($sformatf("sw2_busy_c%0d", i), {31'h0, busy},
          {31'h0, (i <= 8) || (i >= 10 && i <= 17)});
      chk($sformatf("sw2_done_c%0d", i), {31'h0, done}, {31'h0, (i == 9 || i == 18)});
      clr_req = (i == 9);
      step();
      clr_req = 1'b0;
    end
    all_zero("sw2");

    // Reset mid-sweep at counter 4, applied between clock edges.
    fill(32'h200);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 1; i < 5; i++) step();
    raddr_a = 3'd5; raddr_b = 3'd7; #1;
    chk("pre_rst_r5", rdata_a, 32'h205);
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_r5", rdata_a, 32'h0);
    chk("mid_rst_r7", rdata_b, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    step();
    rst = 1'b0;
    begin
      int pulses = 0;
      for (int i = 0; i < 12; i++) begin
        if (done || busy) pulses++;
        step();
      end
      chk("post_rst_quiet", 32'(pulses), 32'h0);
    end
    all_zero("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reg_file_n.md
REG_FILE_N -- requirements
Module: reg_file_n

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register, in bits; legal values are 1 or more.
REQ-002 Parameter DEPTH, default 32: register count; legal values are 2 or more, and powers of two.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and is never written.
REQ-004 Derived constant ADDR_W = clog2(DEPTH).
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 we  in  1  write enable.
REQ-008 wneg  in  1  when 1, store the two's complement of wdata instead of wdata.
REQ-009 waddr  in  ADDR_W  write address.
REQ-010 wdata  in  WIDTH  write data.
REQ-011 raddr_a  in  ADDR_W  read port A address.
REQ-012 raddr_b  in  ADDR_W  read port B address.
REQ-013 rdata_a  out  WIDTH  read port A data.
REQ-014 rdata_b  out  WIDTH  read port B data.
REQ-015 clr_req  in  1  single-cycle request to start a clear sweep.
REQ-016 busy  out  1  high while a clear sweep is in progress.
REQ-017 done  out  1  one-cycle pulse when a clear sweep finishes.

Function
REQ-018 Reads shall be combinational: rdata_x = reg[raddr_x], with 0 latency.
REQ-019 A write shall take effect at the rising clk edge where we=1 and busy=0; the new value is visible on the reads from the following cycle.
REQ-020 A same-cycle read of waddr shall return the old value (no bypass).
REQ-021 Stored value = wneg ? (~wdata + 1) mod 2^WIDTH : wdata.
- wneg with wdata=0 stores 0.
- wneg with wdata=2^(WIDTH-1) stores 2^(WIDTH-1).
REQ-022 With ZERO_REG=1, a write to address 0 shall be discarded and reads of address 0 shall return 0.
REQ-023 With ZERO_REG=0, address 0 shall behave like every other register.
REQ-024 The state machine shall have two states: IDLE and SWEEP.
REQ-025 In IDLE, clr_req=1 shall move to SWEEP with sweep counter = 0 and busy=1 from the next cycle.
- A write presented in the same cycle as clr_req shall still complete.
REQ-026 In SWEEP, each cycle shall zero reg[counter] and then increment the counter.
- When counter = DEPTH-1 is cleared: return to IDLE, busy=0, and done=1 for exactly that next cycle.
- A sweep therefore takes DEPTH cycles.
REQ-027 While busy=1:
- we shall be ignored.
- clr_req shall be ignored (no restart, no queueing).
- Reads shall return the current contents, whether already cleared or not.
REQ-028 clr_req shall be sampled only in IDLE; a back-to-back clr_req in the cycle done=1 shall start a new sweep.

Reset
REQ-029 rst=1 shall, immediately and regardless of clk, set:
- all registers to 0;
- state to IDLE;
- counter to 0;
- busy to 0;
- done to 0.
REQ-030 rst asserted during SWEEP shall abort the sweep with no done pulse.
REQ-031 The first write after rst deasserts shall be accepted at the first rising edge.

Structure
REQ-032 The shared package reg_file_pkg shall hold:
- the state enum {IDLE, SWEEP};
- default WIDTH/DEPTH constants.
REQ-033 The two's-complement datapath shall be one sub-module, negate_n, parametrised by WIDTH (invert plus increment, carry-out discarded).
REQ-034 The register array, counter and FSM shall be in reg_file_n; no other sub-modules.

Verification (WIDTH=32, DEPTH=8, ZERO_REG=1 unless stated)
REQ-035 Write 0xDEADBEEF to reg 3, with raddr_a=3 in the same cycle -> rdata_a=old value (0); 0xDEADBEEF on the next cycle.
REQ-036 Write wdata=5 with wneg=1 to reg 2 -> reads 0xFFFFFFFB; wdata=0x80000000 with wneg=1 -> reads 0x80000000.
REQ-037 Write 0x1234 to reg 0 -> rdata=0. With ZERO_REG=0, the same write -> rdata=0x1234.
REQ-038 Fill regs 1-7, pulse clr_req, attempt a write on cycle 3 -> busy high for 8 cycles, done high on cycle 9 only, the write is discarded, all regs read 0.
REQ-039 Assert rst mid-sweep (counter=4), between clock edges -> all outputs and registers 0 immediately, done never pulses.
REQ-040 Pulse clr_req in the same cycle done=1 -> a second sweep starts, busy stays high for 8 more cycles.
